// File: rtl/radix4_booth_mul_seq.sv
// Sequential radix-4 Booth multiplier with valid/ready handshakes, signed/unsigned
// mode and a global clock enable; one partial product is accumulated per enabled cycle.
module radix4_booth_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int EW = WIDTH + 2;
  localparam int N  = EW / 2;
  localparam int PW = 2 * EW;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      m_q, m_d;      // multiplicand, already scaled by 4^i
  logic [EW:0]        q_q, q_d;      // multiplier; bit 0 holds q[2i-1]
  logic [PW-1:0]      acc_q, acc_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [EW-1:0]      a_ext_s;
  logic [EW-1:0]      b_ext_s;
  logic [PW-1:0]      pp_s;
  logic [PW-1:0]      sum_s;
  logic               last_s;
  logic               load_s;

  assign in_ready  = en & ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign out_valid = en & ~rst & (state_q == DONE);
  assign busy      = ~rst & (state_q == MUL);
  assign product   = prod_q;

  assign load_s = in_valid & in_ready;
  assign last_s = (cnt_q == CW'(N - 1));
  assign sum_s  = acc_q + pp_s;

  // Operand extension to EW bits according to the requested mode
  always_comb begin
    if (signed_mode) begin
      a_ext_s = {{2{a[WIDTH-1]}}, a};
      b_ext_s = {{2{b[WIDTH-1]}}, b};
    end else begin
      a_ext_s = {2'b00, a};
      b_ext_s = {2'b00, b};
    end
  end

  // Booth digit selection from the current multiplier triplet
  always_comb begin
    pp_s = {PW{1'b0}};
    case (q_q[2:0])
      3'b001, 3'b010: pp_s = m_q;
      3'b011:         pp_s = {m_q[PW-2:0], 1'b0};
      3'b100:         pp_s = -{m_q[PW-2:0], 1'b0};
      3'b101, 3'b110: pp_s = -m_q;
      default:        pp_s = {PW{1'b0}};
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    if (load_s) begin
      m_d     = {{EW{a_ext_s[EW-1]}}, a_ext_s};
      q_d     = {b_ext_s, 1'b0};
      acc_d   = {PW{1'b0}};
      cnt_d   = {CW{1'b0}};
      state_d = MUL;
    end else if (en) begin
      case (state_q)
        MUL: begin
          acc_d = sum_s;
          m_d   = {m_q[PW-3:0], 2'b00};
          q_d   = {2'b00, q_q[EW:2]};
          cnt_d = cnt_q + CW'(1);
          if (last_s) begin
            prod_d  = sum_s[2*WIDTH-1:0];
            state_d = DONE;
          end else begin
            state_d = MUL;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      m_q     <= {PW{1'b0}};
      q_q     <= {(EW+1){1'b0}};
      acc_q   <= {PW{1'b0}};
      prod_q  <= {(2*WIDTH){1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: tb/tb_radix4_booth_mul_seq.sv
// Bench for radix4_booth_mul_seq: directed WIDTH=8 scenarios plus a randomised
// WIDTH=16 handshake sweep checked against an arithmetic reference.
module tb_radix4_booth_mul_seq;

  logic clk = 1'b0;
  logic rst;

  logic        en8, iv8, ir8, sm8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        en16, iv16, ir16, sm16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam int NV = 1500;

  always #5 clk = ~clk;

  radix4_booth_mul_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .en(en8), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .signed_mode(sm8), .out_valid(ov8), .out_ready(or8),
    .product(p8), .busy(busy8)
  );

  radix4_booth_mul_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .en(en16), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .signed_mode(sm16), .out_valid(ov16), .out_ready(or16),
    .product(p16), .busy(busy16)
  );

  function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic s);
    longint r;
    if (s) r = longint'($signed(x)) * longint'($signed(y));
    else   r = longint'(x) * longint'(y);
    return r[31:0];
  endfunction

  // Issue one operand set to the 8-bit DUT and wait for its result.
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic s,
                      output logic [15:0] prod, output int lat);
    a8 = x; b8 = y; sm8 = s; iv8 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ir8 !== 1'b1) begin n_fail++; $display("FAIL run8_in_ready got=%b exp=1", ir8); end
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    while (ov8 !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    prod = p8;
  endtask

  task automatic consume8();
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ir8, ov8, busy8} !== 3'b000) begin n_fail++; $display("FAIL reset_outputs got=%b exp=000", {ir8, ov8, busy8}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (p8 !== 16'h0000) begin n_fail++; $display("FAIL reset_product got=%h exp=0000", p8); end
    n_cmp++;
    if ({ir8, ov8, busy8, ir16} !== 4'b1001) begin n_fail++; $display("FAIL reset_idle got=%b exp=1001", {ir8, ov8, busy8, ir16}); end
    @(posedge clk); #1;
  endtask

  task automatic test_signed_min();
    logic [15:0] pr; int lat;
    run8(8'h80, 8'h80, 1'b1, pr, lat);
    n_cmp++;
    if (lat !== 5) begin n_fail++; $display("FAIL min_latency got=%0d exp=5", lat); end
    n_cmp++;
    if (pr !== 16'h4000) begin n_fail++; $display("FAIL min_product got=%h exp=4000", pr); end
    consume8();
  endtask

  task automatic test_modes();
    logic [15:0] pr; int lat;
    run8(8'hFF, 8'hFF, 1'b0, pr, lat);
    n_cmp++;
    if (pr !== 16'hFE01) begin n_fail++; $display("FAIL unsigned_ff got=%h exp=fe01", pr); end
    consume8();
    run8(8'hFF, 8'hFF, 1'b1, pr, lat);
    n_cmp++;
    if (pr !== 16'h0001) begin n_fail++; $display("FAIL signed_ff got=%h exp=0001", pr); end
    consume8();
  endtask

  task automatic test_backpressure();
    logic [15:0] pr; int lat; int bad;
    run8(8'h7F, 8'h81, 1'b1, pr, lat);
    n_cmp++;
    if (pr !== 16'hC0FF) begin n_fail++; $display("FAIL bp_product got=%h exp=c0ff", pr); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov8 !== 1'b1 || p8 !== 16'hC0FF || ir8 !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL bp_hold got=%0d bad cycles exp=0", bad); end
    @(posedge clk); #1;
    consume8();
    @(negedge clk);
    n_cmp++;
    if ({ov8, busy8, ir8} !== 3'b001) begin n_fail++; $display("FAIL bp_release got=%b exp=001", {ov8, busy8, ir8}); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] pr; int lat;
    run8(8'h06, 8'h07, 1'b0, pr, lat);
    n_cmp++;
    if (pr !== 16'h002A) begin n_fail++; $display("FAIL b2b_first got=%h exp=002a", pr); end
    a8 = 8'h03; b8 = 8'h05; sm8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ir8, ov8} !== 2'b11) begin n_fail++; $display("FAIL b2b_ready got=%b exp=11", {ir8, ov8}); end
    @(posedge clk); #1;
    iv8 = 1'b0; or8 = 1'b0;
    n_cmp++;
    if ({busy8, ov8} !== 2'b10 || p8 !== 16'h002A) begin
      n_fail++; $display("FAIL b2b_no_bubble got=busy%b ov%b p=%h exp=busy1 ov0 p=002a", busy8, ov8, p8);
    end
    lat = 0;
    while (ov8 !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat !== 5 || p8 !== 16'h000F) begin n_fail++; $display("FAIL b2b_second got=lat%0d p=%h exp=lat5 p=000f", lat, p8); end
    consume8();
  endtask

  task automatic test_enable_stall();
    int lat; int bad;
    a8 = 8'h9C; b8 = 8'h37; sm8 = 1'b1; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0; bad = 0;
    while (ov8 !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) en8 = 1'b0;
      if (lat == 5) en8 = 1'b1;
      if (!en8 && (ir8 !== 1'b0 || busy8 !== 1'b1 || ov8 !== 1'b0)) bad++;
    end
    n_cmp++;
    if (lat !== 8) begin n_fail++; $display("FAIL stall_latency got=%0d exp=8", lat); end
    n_cmp++;
    if (p8 !== 16'hEA84) begin n_fail++; $display("FAIL stall_product got=%h exp=ea84", p8); end
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL stall_frozen got=%0d bad cycles exp=0", bad); end
    consume8();
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    a8 = 8'h11; b8 = 8'h22; sm8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ir8, ov8, busy8} !== 3'b000) begin n_fail++; $display("FAIL midrst_high got=%b exp=000", {ir8, ov8, busy8}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ir8 !== 1'b1 || p8 !== 16'h0000 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL midrst_after got=ir%b p=%h busy%b exp=ir1 p=0000 busy0", ir8, p8, busy8);
    end
    or8 = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov8 === 1'b1) seen++;
    end
    or8 = 1'b0;
    n_cmp++;
    if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_output got=%0d exp=0", seen); end
    @(posedge clk); #1;
  endtask

  task automatic test_random_sweep();
    logic [31:0] expq[$];
    logic [31:0] pv, ev;
    logic ai, ao;
    int sent, recv, cyc, bad;
    sent = 0; recv = 0; cyc = 0; bad = 0;
    while (recv < NV && cyc < 80000) begin
      en16 = ($urandom_range(0, 9) != 0);
      or16 = ($urandom_range(0, 3) != 0);
      if (!iv16) begin
        sm16 = 1'($urandom_range(0, 1));
        if (sent < NV && $urandom_range(0, 3) != 0) begin
          a16 = 16'($urandom);
          b16 = 16'($urandom);
          iv16 = 1'b1;
        end
      end
      @(negedge clk);
      ai = iv16 & ir16;
      ao = ov16 & or16;
      pv = p16;
      @(posedge clk); #1;
      cyc++;
      if (ao) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_fail++; $display("FAIL sweep_spurious got=%h exp=no output", pv);
        end else begin
          ev = expq.pop_front();
          if (pv !== ev) begin
            n_fail++;
            if (bad < 10) $display("FAIL sweep_product got=%h exp=%h", pv, ev);
            bad++;
          end
        end
        recv++;
      end
      if (ai) begin
        expq.push_back(ref16(a16, b16, sm16));
        iv16 = 1'b0;
        sent++;
      end
    end
    n_cmp++;
    if (recv !== NV) begin n_fail++; $display("FAIL sweep_timeout got=%0d results exp=%0d", recv, NV); end
    n_cmp++;
    if (sent !== recv) begin n_fail++; $display("FAIL sweep_count got=%0d accepts exp=%0d outputs", sent, recv); end
  endtask

  initial begin
    rst = 1'b1;
    en8 = 1'b1; iv8 = 1'b0; or8 = 1'b0; a8 = 8'h00; b8 = 8'h00; sm8 = 1'b0;
    en16 = 1'b1; iv16 = 1'b0; or16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; sm16 = 1'b0;
    test_reset();
    test_signed_min();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_enable_stall();
    test_reset_mid_mul();
    test_random_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
